// File: rtl/mips_dmem_bridge.sv
// MEM-stage load/store bridge: one req/ack bus transaction per load or store, with a pipeline stall and an optional timeout.
// Build option: define DMEM_ALIGN_CHECK_EN to trap misaligned accesses (AdELM/AdESM) instead of masking the low address bits.
module mips_dmem_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] EXResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemStallM,
    output logic        BusErrM,
    output logic        AdELM,
    output logic        AdESM,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_cnt;
    logic [5:0]  r_op;
    logic [1:0]  r_lane;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_is_load;
    logic        w_is_store;
    logic [1:0]  w_size;
    logic        w_mis;
    logic        w_access;
    logic [1:0]  w_lane;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Select the addressed lane of the bus word and sign/zero-extend it.
    function automatic logic [31:0] fmt_load(input logic [5:0] op, input logic [1:0] lane,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   fmt_load = {{24{b[7]}}, b};
            OP_LBU:  fmt_load = {24'h0, b};
            OP_LH:   fmt_load = {{16{h[15]}}, h};
            OP_LHU:  fmt_load = {16'h0, h};
            default: fmt_load = word;
        endcase
    endfunction

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = SZ_WORD;
        case (opM)
            OP_LB, OP_LBU: begin w_is_load  = 1'b1; w_size = SZ_BYTE; end
            OP_LH, OP_LHU: begin w_is_load  = 1'b1; w_size = SZ_HALF; end
            OP_LW:         begin w_is_load  = 1'b1; w_size = SZ_WORD; end
            OP_SB:         begin w_is_store = 1'b1; w_size = SZ_BYTE; end
            OP_SH:         begin w_is_store = 1'b1; w_size = SZ_HALF; end
            OP_SW:         begin w_is_store = 1'b1; w_size = SZ_WORD; end
            default:       ;
        endcase
        // Conflicting read/write strobes are treated as no access.
        w_is_load  = w_is_load  && MemReadM  && !MemWriteM;
        w_is_store = w_is_store && MemWriteM && !MemReadM;

        case (w_size)
            SZ_BYTE: w_lane = EXResultM[1:0];
            SZ_HALF: w_lane = {EXResultM[1], 1'b0};
            default: w_lane = 2'b00;
        endcase

`ifdef DMEM_ALIGN_CHECK_EN
        w_mis = ((w_size == SZ_HALF) && EXResultM[0]) ||
                ((w_size == SZ_WORD) && (EXResultM[1:0] != 2'b00));
`else
        w_mis = 1'b0;
`endif
        w_access = (w_is_load || w_is_store) && !w_mis;

        case (w_size)
            SZ_BYTE: begin w_be = 4'b0001 << w_lane;                 w_wdata = {4{WriteDataM[7:0]}};  end
            SZ_HALF: begin w_be = w_lane[1] ? 4'b1100 : 4'b0011;     w_wdata = {2{WriteDataM[15:0]}}; end
            default: begin w_be = 4'b1111;                           w_wdata = WriteDataM;            end
        endcase
        if (!w_is_store)
            w_wdata = 32'h0;
    end

    // NOTE: async reset in the sensitivity list; state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 32'h0;
            r_op       <= 6'h0;
            r_lane     <= 2'b00;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_be    <= 4'h0;
            dbus_addr  <= 32'h0;
            dbus_wdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_op       <= opM;
                        r_lane     <= w_lane;
                        r_cnt      <= 32'h0;
                        r_err      <= 1'b0;
                        dbus_we    <= w_is_store;
                        dbus_be    <= w_be;
                        dbus_addr  <= {EXResultM[31:2], 2'b00};
                        dbus_wdata <= w_wdata;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (dbus_ack) begin
                        r_rdata <= dbus_we ? 32'h0 : fmt_load(r_op, r_lane, dbus_rdata);
                        r_state <= S_DONE;
                    end else if (TIMEOUT != 0 && r_cnt == 32'(TIMEOUT - 1)) begin
                        r_rdata <= 32'h0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 32'h1;
                    end
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stall and trap outputs are forced low while reset is held, even with an access pending.
    assign dbus_req  = (r_state == S_BUSY);
    assign MemStallM = !rst && (((r_state == S_IDLE) && w_access) || (r_state == S_BUSY));
    assign ReadDataM = (r_state == S_DONE) ? r_rdata : 32'h0;
    assign BusErrM   = (r_state == S_DONE) && r_err;

`ifdef DMEM_ALIGN_CHECK_EN
    assign AdELM = !rst && (r_state == S_IDLE) && w_is_load  && w_mis;
    assign AdESM = !rst && (r_state == S_IDLE) && w_is_store && w_mis;
`else
    assign AdELM = 1'b0;
    assign AdESM = 1'b0;
`endif

endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Scoreboard bench for mips_dmem_bridge: expected results are queued at issue and compared when the access completes.
module tb_mips_dmem_bridge;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opM;
    logic        MemReadM, MemWriteM;
    logic [31:0] EXResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemStallM, BusErrM, AdELM, AdESM;
    logic        dbus_req, dbus_we;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_addr, dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] rdata;
        int          stall;
        int          req;
        logic [3:0]  be;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        berr;
        logic        adel;
        logic        ades;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    mips_dmem_bridge #(.TIMEOUT(TO)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .opM        (opM),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .EXResultM  (EXResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .MemStallM  (MemStallM),
        .BusErrM    (BusErrM),
        .AdELM      (AdELM),
        .AdESM      (AdESM),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_be    (dbus_be),
        .dbus_addr  (dbus_addr),
        .dbus_wdata (dbus_wdata),
        .dbus_ack   (dbus_ack),
        .dbus_rdata (dbus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Reference behaviour; ack_at is the 1-based BUSY cycle carrying ack (0 = never).
    function automatic exp_t model(input logic [5:0] op, input logic rd, input logic wr,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input int ack_at, input logic [31:0] word);
        exp_t        e;
        logic        ld, st, mis;
        logic [1:0]  ln;
        logic [31:0] w;
        e = '{rdata: 32'h0, stall: 0, req: 0, be: 4'h0, addr: 32'h0, we: 1'b0,
              wdata: 32'h0, berr: 1'b0, adel: 1'b0, ades: 1'b0};
        ld  = rd && !wr && (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25});
        st  = wr && !rd && (op inside {6'h28, 6'h29, 6'h2B});
        mis = (op[1:0] == 2'b01 && a[0]) || (op[1:0] == 2'b11 && a[1:0] != 2'b00);
        if (!(ld || st)) return e;
`ifdef DMEM_ALIGN_CHECK_EN
        if (mis) begin
            e.adel = ld;
            e.ades = st;
            return e;
        end
`endif
        ln = (op[1:0] == 2'b00) ? a[1:0] : (op[1:0] == 2'b01) ? {a[1], 1'b0} : 2'b00;
        e.addr  = {a[31:2], 2'b00};
        e.we    = st;
        e.be    = (op[1:0] == 2'b00) ? (4'b0001 << ln) : (op[1:0] == 2'b01) ? (4'b0011 << ln) : 4'hF;
        e.wdata = !st ? 32'h0 : (op[1:0] == 2'b00) ? {4{wd[7:0]}} :
                  (op[1:0] == 2'b01) ? {2{wd[15:0]}} : wd;
        if (ack_at == 0 || ack_at > TO) begin
            e.req   = TO;
            e.stall = TO + 1;
            e.berr  = 1'b1;
        end else begin
            e.req   = ack_at;
            e.stall = ack_at + 1;
            w = word >> (8 * ln);
            if (ld) begin
                case (op)
                    6'h20:   e.rdata = {{24{w[7]}}, w[7:0]};
                    6'h24:   e.rdata = {24'h0, w[7:0]};
                    6'h21:   e.rdata = {{16{w[15]}}, w[15:0]};
                    6'h25:   e.rdata = {16'h0, w[15:0]};
                    default: e.rdata = word;
                endcase
            end
        end
        return e;
    endfunction

    // Entered at posedge+1 with the DUT idle; leaves at posedge+1 with the DUT idle again.
    task automatic run_access(input string tag, input logic [5:0] op, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_at, input logic [31:0] word);
        exp_t        e;
        int          stall_n = 0, req_n = 0, busy = 0;
        bit          done = 0;
        logic [3:0]  s_be = 4'h0;
        logic [31:0] s_addr = 32'h0, s_wdata = 32'h0;
        logic        s_we = 1'b0;
        sb_q.push_back(model(op, rd, wr, a, wd, ack_at, word));
        opM = op; MemReadM = rd; MemWriteM = wr; EXResultM = a; WriteDataM = wd;
        dbus_rdata = word;
        for (int n = 0; n < 400; n++) begin
            #1;
            if (MemStallM === 1'b0) begin done = 1; break; end
            stall_n++;
            if (dbus_req === 1'b1) begin
                req_n++;
                busy++;
                if (busy == 1) begin
                    s_be = dbus_be; s_addr = dbus_addr; s_we = dbus_we; s_wdata = dbus_wdata;
                end
            end
            dbus_ack = (ack_at != 0 && busy == ack_at);
            @(posedge clk);
            #1 dbus_ack = 1'b0;
        end
        check({tag, ".finished"}, 32'(done), 32'd1);
        e = sb_q.pop_front();
        check({tag, ".rdata"}, ReadDataM, e.rdata);
        check({tag, ".stall"}, 32'(stall_n), 32'(e.stall));
        check({tag, ".req"},   32'(req_n), 32'(e.req));
        check({tag, ".berr"},  32'(BusErrM), 32'(e.berr));
        check({tag, ".adel"},  32'(AdELM), 32'(e.adel));
        check({tag, ".ades"},  32'(AdESM), 32'(e.ades));
        if (e.req > 0) begin
            check({tag, ".be"},    32'(s_be), 32'(e.be));
            check({tag, ".addr"},  s_addr, e.addr);
            check({tag, ".we"},    32'(s_we), 32'(e.we));
            check({tag, ".wdata"}, s_wdata, e.wdata);
        end
        opM = 6'h0; MemReadM = 1'b0; MemWriteM = 1'b0;
        @(posedge clk);
        #1;
        if (e.berr) begin
            #1 check({tag, ".berr_pulse"}, 32'(BusErrM), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; opM = 6'h0; MemReadM = 1'b0; MemWriteM = 1'b0;
        EXResultM = 32'h0; WriteDataM = 32'h0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        #3;
        check("rst.ReadDataM", ReadDataM, 32'h0);
        check("rst.MemStallM", 32'(MemStallM), 32'd0);
        check("rst.BusErrM",   32'(BusErrM), 32'd0);
        check("rst.AdELM",     32'(AdELM), 32'd0);
        check("rst.AdESM",     32'(AdESM), 32'd0);
        check("rst.req",       32'(dbus_req), 32'd0);
        check("rst.we",        32'(dbus_we), 32'd0);
        check("rst.be",        32'(dbus_be), 32'd0);
        check("rst.addr",      dbus_addr, 32'h0);
        check("rst.wdata",     dbus_wdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        run_access("lw_100",   6'h23, 1, 0, 32'h0000_0100, 32'h0,         1, 32'hDEAD_BEEF);
        run_access("lb_103",   6'h20, 1, 0, 32'h0000_0103, 32'h0,         1, 32'h80FF_1234);
        run_access("lbu_103",  6'h24, 1, 0, 32'h0000_0103, 32'h0,         1, 32'h80FF_1234);
        run_access("sh_202",   6'h29, 0, 1, 32'h0000_0202, 32'h0000_ABCD, 5, 32'h5555_AAAA);
        run_access("lw_tmo",   6'h23, 1, 0, 32'h0000_0400, 32'h0,         0, 32'h1111_2222);
        run_access("lw_ackTO", 6'h23, 1, 0, 32'h0000_0404, 32'h0,        TO, 32'hCAFE_F00D);
        run_access("lh_102",   6'h21, 1, 0, 32'h0000_0102, 32'h0,         1, 32'h8001_7FFF);
        run_access("lhu_100",  6'h25, 1, 0, 32'h0000_0100, 32'h0,         2, 32'h8001_FFFE);
        run_access("sb_001",   6'h28, 0, 1, 32'h0000_0001, 32'h1234_565A, 2, 32'h0);
        run_access("sw_010",   6'h2B, 0, 1, 32'h0000_0010, 32'h1234_5678, 3, 32'h0);
        run_access("lh_101",   6'h21, 1, 0, 32'h0000_0101, 32'h0,         1, 32'h7654_F3A1);
        run_access("sw_013",   6'h2B, 0, 1, 32'h0000_0013, 32'h8765_4321, 1, 32'h0);
        run_access("rw_both",  6'h23, 1, 1, 32'h0000_0100, 32'h0,         1, 32'h0);
        run_access("op_none",  6'h0F, 1, 0, 32'h0000_0100, 32'h0,         1, 32'h0);

        // Reset while BUSY, then a stray ack from the aborted transfer.
        opM = 6'h23; MemReadM = 1'b1; EXResultM = 32'h0000_0300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid.req_before", 32'(dbus_req), 32'd1);
        rst = 1'b1;
        #1;
        check("mid.req",   32'(dbus_req), 32'd0);
        check("mid.stall", 32'(MemStallM), 32'd0);
        check("mid.rdata", ReadDataM, 32'h0);
        @(posedge clk); #1;
        opM = 6'h0; MemReadM = 1'b0; rst = 1'b0;
        dbus_ack = 1'b1; dbus_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1 dbus_ack = 1'b0;
        #1;
        check("late_ack.req",   32'(dbus_req), 32'd0);
        check("late_ack.stall", 32'(MemStallM), 32'd0);
        check("late_ack.rdata", ReadDataM, 32'h0);
        @(posedge clk); #1;
        run_access("lw_after", 6'h23, 1, 0, 32'h0000_0300, 32'h0, 1, 32'h0BAD_F00D);

        check("sb_q.empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
